// File: rtl/rddma_sink.sv
// rddma_sink: DMA stream sink that counts beats and frames per channel.
// Define RDDMA_SINK_CHECKSUM_EN to build the per-channel XOR checksum registers.
module rddma_sink #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 32,
  parameter int NUM_CH = 2,
  parameter int STALL_PERIOD = 0,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_last,
  input  logic [CH_W-1:0]          s_chan,
  output logic [NUM_CH*CNT_W-1:0]  beat_cnt,
  output logic [NUM_CH*CNT_W-1:0]  frame_cnt,
  output logic [NUM_CH-1:0]        ovf,
  output logic                     bad_chan,
  output logic                     busy,
  output logic [NUM_CH*DATA_W-1:0] checksum
);
  localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;
  state_t state;
  logic [SC_W-1:0] stall_cnt;
  logic xfer;
  logic bad;
  assign xfer = s_valid & s_ready;
  assign bad = 32'(s_chan) >= NUM_CH;
  assign busy = state != IDLE;
  // stall_cnt counts transfers since entering RUN; it is zeroed whenever ready drops
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) begin
      state <= IDLE;
      s_ready <= 1'b0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          state <= RUN;
          s_ready <= 1'b1;
        end
        RUN: if (!enable) begin
          state <= IDLE;
          s_ready <= 1'b0;
          stall_cnt <= '0;
        end else if (xfer) begin
          if (STALL_PERIOD > 0 && stall_cnt == SC_LAST) begin
            state <= STALL;
            s_ready <= 1'b0;
            stall_cnt <= '0;
          end else
            stall_cnt <= stall_cnt + SC_W'(1);
        end
        STALL: begin
          state <= enable ? RUN : IDLE;
          s_ready <= enable;
        end
        default: begin
          state <= IDLE;
          s_ready <= 1'b0;
          stall_cnt <= '0;
        end
      endcase
    end
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) bad_chan <= 1'b0;
    else if (clear) bad_chan <= 1'b0;
    else if (xfer && bad) bad_chan <= 1'b1;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] fc;
    logic o;
    assign hit = xfer && s_chan == CH_W'(c);
    always_ff @(posedge sys_clk or negedge sys_rst)
      if (!sys_rst) begin
        bc <= '0;
        fc <= '0;
        o <= 1'b0;
      end else if (clear) begin
        bc <= '0;
        fc <= '0;
        o <= 1'b0;
      end else if (hit) begin
        bc <= bc + CNT_W'(1);
        fc <= fc + CNT_W'(s_last);
        if (&bc) o <= 1'b1;
      end
    assign beat_cnt[c*CNT_W +: CNT_W] = bc;
    assign frame_cnt[c*CNT_W +: CNT_W] = fc;
    assign ovf[c] = o;
`ifdef RDDMA_SINK_CHECKSUM_EN
    logic [DATA_W-1:0] cs;
    always_ff @(posedge sys_clk or negedge sys_rst)
      if (!sys_rst) cs <= '0;
      else if (clear) cs <= '0;
      else if (hit) cs <= cs ^ s_data;
    assign checksum[c*DATA_W +: DATA_W] = cs;
`else
    assign checksum[c*DATA_W +: DATA_W] = '0;
`endif
  end
`ifndef RDDMA_SINK_CHECKSUM_EN
  logic unused_data;
  assign unused_data = ^s_data;
`endif
endmodule

// File: tb/tb_rddma_sink.sv
// tb_rddma_sink: randomized check of rddma_sink against a behavioural per-channel model.
module tb_rddma_sink;
  localparam int DW = 32, CW = 8, NC = 3, SP = 4, CHW = 2;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic enable = 1'b0, clear = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic s_ready, bad_chan, busy;
  logic [DW-1:0] s_data = '0;
  logic [CHW-1:0] s_chan = '0;
  logic [NC*CW-1:0] beat_cnt, frame_cnt;
  logic [NC-1:0] ovf;
  logic [NC*DW-1:0] checksum;
  int n_chk = 0, n_fail = 0;
  int m_beat[NC], m_frame[NC];
  logic [NC-1:0] m_ovf;
  logic [DW-1:0] m_cs[NC];
  logic m_bad, m_ready, m_busy;
  int seg;
  string ph = "init";

  always #5 sys_clk = ~sys_clk;

  rddma_sink #(.DATA_W(DW), .CNT_W(CW), .NUM_CH(NC), .STALL_PERIOD(SP)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .s_chan(s_chan), .beat_cnt(beat_cnt), .frame_cnt(frame_cnt), .ovf(ovf),
    .bad_chan(bad_chan), .busy(busy), .checksum(checksum)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NC; i++) begin
      m_beat[i] = 0;
      m_frame[i] = 0;
      m_cs[i] = '0;
    end
    m_ovf = '0;
    m_bad = 1'b0;
  endtask

  task automatic model_reset();
    clear_counts();
    m_ready = 1'b0;
    m_busy = 1'b0;
    seg = 0;
  endtask

  task automatic compare_all();
    logic [NC*CW-1:0] eb, ef;
    logic [NC*DW-1:0] ec;
    for (int i = 0; i < NC; i++) begin
      eb[i*CW +: CW] = CW'(m_beat[i]);
      ef[i*CW +: CW] = CW'(m_frame[i]);
      ec[i*DW +: DW] = m_cs[i];
    end
`ifndef RDDMA_SINK_CHECKSUM_EN
    ec = '0;
`endif
    check({ph, " s_ready"}, s_ready, m_ready);
    check({ph, " busy"}, busy, m_busy);
    check({ph, " beat_cnt"}, beat_cnt, eb);
    check({ph, " frame_cnt"}, frame_cnt, ef);
    check({ph, " ovf"}, ovf, m_ovf);
    check({ph, " bad_chan"}, bad_chan, m_bad);
    check({ph, " checksum"}, checksum, ec);
  endtask

  // One clock: drive inputs, advance the model by the edge's rules, compare after the edge.
  task automatic cycle(input logic en, input logic clr, input logic v, input logic l,
                       input logic [CHW-1:0] ch, input logic [DW-1:0] d);
    logic x;
    enable = en; clear = clr; s_valid = v; s_last = l; s_chan = ch; s_data = d;
    if (!sys_rst) model_reset();
    else begin
      x = v && m_ready;
      if (clr) clear_counts();
      else if (x) begin
        if (int'(ch) < NC) begin
          m_beat[ch] = (m_beat[ch] + 1) % 256;
          if (m_beat[ch] == 0) m_ovf[ch] = 1'b1;
          if (l) m_frame[ch] = (m_frame[ch] + 1) % 256;
          m_cs[ch] = m_cs[ch] ^ d;
        end else m_bad = 1'b1;
      end
      if (x) seg++;
      m_busy = en;
      m_ready = en && !(x && seg == SP);
      if (!m_ready) seg = 0;
    end
    @(posedge sys_clk);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [CHW-1:0] ch, input logic [DW-1:0] d, input logic l);
    for (int i = 0; i < 8; i++) begin
      if (m_ready) begin
        cycle(1, 0, 1, l, ch, d);
        return;
      end
      cycle(1, 0, 0, 0, 0, 0);
    end
    check("send_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1 sys_rst = 1'b0;
    #1 ph = "reset";
    compare_all();
    @(posedge sys_clk);
    #1;
    repeat (2) cycle(1, 0, 1, 0, 0, 0);
    sys_rst = 1'b1;
    ph = "idle";
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    ph = "stall";
    repeat (12) cycle(1, 0, 1, 0, 0, $urandom);
    check("stall_beats", beat_cnt[CW-1:0], 9);
    ph = "wrap";
    for (int i = 0; i < 400 && m_beat[1] != 255; i++) cycle(1, 0, 1, 0, 1, $urandom);
    for (int i = 0; i < 8 && m_beat[1] != 0; i++) cycle(1, 0, 1, 0, 1, $urandom);
    check("wrap_b1", beat_cnt[2*CW-1:CW], 0);
    check("wrap_ovf", ovf, 3'b010);
    check("wrap_b0", beat_cnt[CW-1:0], 9);
    ph = "bad";
    send(3, $urandom, 1);
    send(3, $urandom, 0);
    check("bad_flag", bad_chan, 1);
    check("bad_b0", beat_cnt[CW-1:0], 9);
    ph = "clear";
    for (int i = 0; i < 8 && !m_ready; i++) cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 32'h12345678);
    check("clr_beat", beat_cnt, 0);
    check("clr_frame", frame_cnt, 0);
    check("clr_cs", checksum, 0);
    check("clr_flags", {ovf, bad_chan}, 0);
    send(0, 32'hA5A5A5A5, 0);
    send(0, 32'h0F0F0F0F, 1);
`ifdef RDDMA_SINK_CHECKSUM_EN
    check("cs_pattern", checksum[DW-1:0], 32'hAAAAAAAA);
`else
    check("cs_tied", checksum, 0);
`endif
    check("cs_frames", frame_cnt[CW-1:0], 1);
    ph = "rand";
    repeat (3000)
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, CHW'($urandom_range(0, 3)), $urandom);
    ph = "areset";
    repeat (6) cycle(1, 0, 1, 0, 2, $urandom);
    #2 sys_rst = 1'b0;
    #1 model_reset();
    compare_all();
    cycle(1, 0, 1, 1, 0, $urandom);
    sys_rst = 1'b1;
    ph = "post";
    repeat (2) cycle(0, 0, 1, 0, 0, $urandom);
    repeat (20) cycle(1, 0, 1, $urandom_range(0, 1), CHW'($urandom_range(0, 2)), $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rddma_sink.md
RDDMA_SINK -- requirements
Module: rddma_sink

Interface
REQ-001 Parameter DATA_W, 32, stream data width in bits (8..512).
REQ-002 Parameter CNT_W, 32, width of every counter (8..64).
REQ-003 Parameter NUM_CH, 2, number of DMA channels tracked (1..16); CH_W = max(1, clog2(NUM_CH)).
REQ-004 Parameter STALL_PERIOD, 0, accepted beats between forced one-cycle ready drops; 0 = never stall.
REQ-005 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-006 sys_rst  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  run request; level sensitive.
REQ-008 clear  in  1  synchronous one-cycle pulse; zeroes counters, flags and checksums.
REQ-009 s_valid  in  1  upstream DMA FIFO has a beat.
REQ-010 s_ready  out  1  sink accepts a beat.
REQ-011 s_data  in  DATA_W  beat payload.
REQ-012 s_last  in  1  final beat of a frame.
REQ-013 s_chan  in  CH_W  channel ID of beat.
REQ-014 beat_cnt  out  NUM_CH*CNT_W  accepted beats per channel; channel i at [i*CNT_W +: CNT_W].
REQ-015 frame_cnt  out  NUM_CH*CNT_W  accepted s_last beats per channel.
REQ-016 ovf  out  NUM_CH  sticky beat-counter wrap flag per channel.
REQ-017 bad_chan  out  1  sticky flag: beat with s_chan >= NUM_CH accepted.
REQ-018 busy  out  1  high when FSM not IDLE.
REQ-019 checksum  out  NUM_CH*DATA_W  per-channel XOR of accepted data (see Configuration).

Function
REQ-020 A transfer occurs on a rising edge where s_valid and s_ready are both 1; no other condition counts a beat.
REQ-021 s_ready is a register output with no combinational path from s_valid, s_data, s_last or s_chan.
REQ-022 FSM states: IDLE (s_ready 0), RUN (s_ready 1), STALL (s_ready 0, exactly one cycle).
REQ-023 IDLE -> RUN when enable = 1; RUN -> IDLE when enable = 0; STALL -> RUN if enable = 1, else IDLE.
REQ-024 With STALL_PERIOD = N > 0, RUN -> STALL on the cycle of the N-th transfer since entering RUN or leaving STALL; the stall-interval counter zeroes on entry to IDLE.
REQ-025 Counter latency is one cycle: the transfer at edge k is visible on beat_cnt/frame_cnt after edge k.
REQ-026 A transfer in the same cycle enable falls is counted; s_ready is 0 from the next cycle.
REQ-027 Counters wrap modulo 2^CNT_W; a beat_cnt wrap from all-ones to 0 sets that channel's ovf.
REQ-028 A beat with s_chan >= NUM_CH is handshaked, is not counted, and sets bad_chan.
REQ-029 If clear coincides with a transfer, clear wins: all counters read 0 after the edge and the beat is handshaked but not counted.
REQ-030 clear does not change FSM state or the stall-interval counter.

Reset
REQ-031 sys_rst low asynchronously forces FSM to IDLE, s_ready 0, and beat_cnt, frame_cnt, ovf, bad_chan, checksum and the stall-interval counter to 0.
REQ-032 Reset asserted mid-frame discards partial state; no beat is counted on the reset edge.
REQ-033 After reset release, the FSM leaves IDLE no earlier than the first rising edge with enable = 1.

Configuration
REQ-034 With macro RDDMA_SINK_CHECKSUM_EN defined, checksum[i] ^= s_data on each counted transfer on channel i, with the same latency, clear and reset rules as beat_cnt.
REQ-035 Without RDDMA_SINK_CHECKSUM_EN, checksum is tied to constant 0 and no checksum registers are built.

Verification
REQ-036 Reset, enable = 1, s_valid constant 1, s_chan = 0, 10 cycles, STALL_PERIOD = 0 -> s_ready 1 from cycle 2, beat_cnt[0] = 9 after 10 edges, busy = 1.
REQ-037 STALL_PERIOD = 4, s_valid constant 1 -> s_ready pattern 1111 0 1111 0 ..., exactly 8 beats in 10 RUN/STALL cycles.
REQ-038 CNT_W = 8, preload 255 beats on ch1, send one more -> beat_cnt[1] = 0, ovf = 2'b10, beat_cnt[0] unchanged.
REQ-039 NUM_CH = 3, beat with s_chan = 3 -> s_ready handshake completes, no counter changes, bad_chan = 1 until clear.
REQ-040 clear pulsed on a cycle with a transfer on ch0 and s_last = 1 -> beat_cnt, frame_cnt and checksum read 0 next cycle; with the macro, data 0xA5A5A5A5 then 0x0F0F0F0F -> checksum[0] = 0xAAAAAAAA.
REQ-041 sys_rst asserted asynchronously mid-burst, between edges -> s_ready and all counters are 0 immediately, with no clock edge required.
